// File: rtl/d_de_serializer.sv
// d_de_serializer: loads a parallel word on a Start/Ready handshake and
// presents it MSB-first on D, one bit per De=1 cycle. GAP idle cycles can
// be inserted between bits so the downstream flops see both continuous
// and gapped enables. A one-cycle Done pulse closes each frame.
module d_de_serializer #(
    parameter int WIDTH = 8,   // bits per frame (2..16)
    parameter int CNT_W = 3,   // ceil(log2(WIDTH))
    parameter int GAP   = 0    // De=0 cycles between consecutive bits (0..15)
) (
    input  logic             Clk,
    input  logic             Reset_b,
    input  logic             Start,
    input  logic [WIDTH-1:0] Din,
    output logic             Ready,
    output logic             D,
    output logic             De,
    output logic             Done,
    output logic [CNT_W-1:0] Bit_cnt
);

    typedef enum logic [1:0] {
        QI = 2'd0,  // idle, waiting for Start
        QS = 2'd1,  // presenting one bit with De=1
        QG = 2'd2,  // inter-bit gap, De=0
        QD = 2'd3   // one-cycle Done
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam bit               HAS_GAP  = (GAP > 0);
    // Terminal value of the gap counter; only meaningful when HAS_GAP.
    localparam logic [3:0]       GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       gap_cnt;
    logic [3:0]       gap_nxt;

    // State and datapath registers; reset clears everything so a partial
    // frame is dropped without a Done.
    // NOTE: the shift register is reset as well, so D is a known 0 from the
    // first cycle instead of depending on power-up contents.
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state   <= QI;
            sr      <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state   <= state_nxt;
            sr      <= sr_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        // NOTE: hold-value defaults first, so no path leaves a target
        // unassigned and no latch is inferred.
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;

        unique case (state)
            QI: begin
                // Level-sampled Start; Din is only captured here.
                if (Start) begin
                    sr_nxt    = Din;
                    cnt_nxt   = '0;
                    state_nxt = QS;
                end
            end
            QS: begin
                sr_nxt = {sr[WIDTH-2:0], 1'b0};
                if (cnt == LAST_BIT) begin
                    // The last bit is never followed by a gap.
                    cnt_nxt   = '0;
                    state_nxt = QD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (HAS_GAP) begin
                        gap_nxt   = '0;
                        state_nxt = QG;
                    end
                end
            end
            QG: begin
                gap_nxt = gap_cnt + 4'd1;
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = QS;
                end
            end
            QD: begin
                state_nxt = QI;
            end
            default: begin
                state_nxt = QI;
            end
        endcase
    end

    // Moore outputs, decoded from the state register only.
    assign Ready   = (state == QI);
    assign De      = (state == QS);
    assign D       = (state == QS) ? sr[WIDTH-1] : 1'b0;
    assign Done    = (state == QD);
    assign Bit_cnt = cnt;

endmodule

// File: tb/tb_d_de_serializer.sv
// Testbench for d_de_serializer: one instance with GAP=0 and one with GAP=2.
// Expected per-cycle outputs are generated from a behavioural frame model
// into a queue when a frame is started and popped every cycle.
module tb_d_de_serializer;

    typedef struct packed {
        logic       ready;
        logic       de;
        logic       d;
        logic       done;
        logic [2:0] cnt;
    } obs_t;

    typedef struct {
        int         sel;       // 0: GAP=0 instance, 2: GAP=2 instance
        logic [7:0] din;
        logic [7:0] exp_bits;  // serial order, first bit in [7]
        int         exp_done;  // cycle of Done, counted from the accept edge
        int         busy_lo;   // Start=1,Din=FF driven for cycles [lo,hi)
        int         busy_hi;
    } vec_t;

    localparam obs_t IDLE = 7'b1000000;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       start0 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] din0   = '0;
    logic [7:0] din2   = '0;
    logic       ready0, d0, de0, done0;
    logic       ready2, d2, de2, done2;
    logic [2:0] cnt0, cnt2;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    always #15 clk = ~clk;

    d_de_serializer #(.WIDTH(8), .CNT_W(3), .GAP(0)) dut0 (
        .Clk(clk), .Reset_b(rst_n), .Start(start0), .Din(din0),
        .Ready(ready0), .D(d0), .De(de0), .Done(done0), .Bit_cnt(cnt0)
    );

    d_de_serializer #(.WIDTH(8), .CNT_W(3), .GAP(2)) dut2 (
        .Clk(clk), .Reset_b(rst_n), .Start(start2), .Din(din2),
        .Ready(ready2), .D(d2), .De(de2), .Done(done2), .Bit_cnt(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) o = {ready0, de0, d0, done0, cnt0};
        else          o = {ready2, de2, d2, done2, cnt2};
        return o;
    endfunction

    task automatic drive(input int sel, input logic s, input logic [7:0] v);
        if (sel == 0) begin start0 = s; din0 = v; end
        else          begin start2 = s; din2 = v; end
    endtask

    // Frame model: bits MSB-first, GAP idle cycles after every bit but the
    // last (Bit_cnt already points at the next bit), then Done, then idle.
    task automatic push_frame(input int gap, input logic [7:0] din);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b0, 1'b1, din[7-i], 1'b0, 3'(i)});
            if (i < 7)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 3'(i + 1)});
        end
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        exp_q.push_back(IDLE);
    endtask

    // Starts one frame from idle (entered just after a falling edge) and
    // compares every cycle until the idle cycle following Done.
    task automatic run_frame(input vec_t v, input string tag);
        obs_t       o, e;
        logic [7:0] bits;
        int         nb, done_at, n, c;
        bits = '0; nb = 0; done_at = -1;
        check({tag, " idle"}, sample(v.sel), IDLE);
        push_frame((v.sel == 0) ? 0 : 2, v.din);
        drive(v.sel, 1'b1, v.din);
        @(posedge clk);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c = k + 1;
            o = sample(v.sel);
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", tag, c), o, e);
            if (o.de) begin bits = {bits[6:0], o.d}; nb++; end
            if (o.done && done_at < 0) done_at = c;
            if (c >= v.busy_lo && c < v.busy_hi) drive(v.sel, 1'b1, 8'hFF);
            else                                 drive(v.sel, 1'b0, 8'h00);
        end
        check({tag, " bits"}, bits, v.exp_bits);
        check({tag, " nbits"}, nb, 8);
        check({tag, " done_cycle"}, done_at, v.exp_done);
    endtask

    // Start held high: frames repeat with exactly two De=0 cycles between.
    task automatic run_continuous(input logic [7:0] din, input int frames);
        obs_t o, e;
        int   n, last_de, done_cnt;
        last_de = -1; done_cnt = 0;
        for (int f = 0; f < frames; f++) push_frame(0, din);
        drive(0, 1'b1, din);
        @(posedge clk);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            o = sample(0);
            e = exp_q.pop_front();
            check($sformatf("cont c%0d", k + 1), o, e);
            if (o.de) begin
                if (last_de >= 0 && (k - last_de) > 1)
                    check("cont de_gap", k - last_de - 1, 2);
                last_de = k;
            end
            if (o.done) done_cnt++;
            if (k == n - 1) drive(0, 1'b0, 8'h00);
        end
        check("cont frames", done_cnt, frames);
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{sel: 0, din: 8'hA5, exp_bits: 8'b10100101, exp_done: 9,  busy_lo: 0, busy_hi: 0};
        vecs[1] = '{sel: 2, din: 8'hC3, exp_bits: 8'b11000011, exp_done: 23, busy_lo: 0, busy_hi: 0};
        vecs[2] = '{sel: 0, din: 8'hA5, exp_bits: 8'b10100101, exp_done: 9,  busy_lo: 3, busy_hi: 7};
        vecs[3] = '{sel: 0, din: 8'h00, exp_bits: 8'b00000000, exp_done: 9,  busy_lo: 0, busy_hi: 0};
        vecs[4] = '{sel: 0, din: 8'hFF, exp_bits: 8'b11111111, exp_done: 9,  busy_lo: 0, busy_hi: 0};
        vecs[5] = '{sel: 2, din: 8'h5A, exp_bits: 8'b01011010, exp_done: 23, busy_lo: 5, busy_hi: 12};
        vecs[6] = '{sel: 2, din: 8'h81, exp_bits: 8'b10000001, exp_done: 23, busy_lo: 0, busy_hi: 0};

        // Reset: takes effect without a clock, holds with Start/Din active.
        #2 rst_n = 1'b0;
        #1;
        check("rst async g0", sample(0), IDLE);
        check("rst async g2", sample(2), IDLE);
        drive(0, 1'b1, 8'hFF);
        drive(2, 1'b1, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst hold g0 %0d", i), sample(0), IDLE);
            check($sformatf("rst hold g2 %0d", i), sample(2), IDLE);
        end
        drive(0, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post rst g0", sample(0), IDLE);
        check("post rst g2", sample(2), IDLE);

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        run_continuous(8'h81, 3);

        // Async reset 5 ns after the edge that presents the third bit.
        drive(0, 1'b1, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        check("mid bit0", sample(0), 7'b0110000);
        @(negedge clk);
        check("mid bit1", sample(0), 7'b0100001);
        @(posedge clk);
        #4;
        check("mid bit2", sample(0), 7'b0110010);
        #1 rst_n = 1'b0;
        #1;
        check("mid rst async", sample(0), IDLE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid rst hold %0d", i), sample(0), IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_frame('{sel: 0, din: 8'h01, exp_bits: 8'b00000001, exp_done: 9, busy_lo: 0, busy_hi: 0},
                  "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
